// File: rtl/tcp_rcv_pkg.sv
// Purpose: shared types and constants for the TCP receive segment memory.
// Contents: FSM state encoding, buffer geometry, payload byte-to-word helper.
// Used by: tcp_rcv_memory (top) and its testbench.
package tcp_rcv_pkg;

  localparam int unsigned RCV_ADDR_W  = 9;     // 512 x 32-bit words
  localparam int unsigned RCV_MAX_LEN = 2048;  // largest payload we buffer

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DISCARD,
    ST_CHECK,
    ST_FULL
  } state_e;

  // Number of 32-bit words occupied by a payload of len bytes: ceil(len/4).
  function automatic logic [15:0] word_count(input logic [15:0] len);
    return 16'((17'(len) + 17'd3) >> 2);
  endfunction

endpackage

// File: rtl/tcp_rcv_memory_if.sv
// Purpose: bundles the parser, controller and reader signals of the receive memory.
// Modports: master = parser/controller/reader side, slave = tcp_rcv_memory.
// Names keep the _i/_o direction suffixes as seen from the memory block.
interface tcp_rcv_memory_if;

  logic        controller_work_st_i;
  logic        init_seq_ld_i;
  logic [31:0] init_seq_i;
  logic        seg_sop_i;
  logic [31:0] seg_seq_num_i;
  logic [15:0] seg_len_i;
  logic        seg_fin_flag_i;
  logic        seg_rst_flag_i;
  logic        seg_wr_i;
  logic [31:0] seg_dat_i;
  logic        seg_eop_i;
  logic        seg_err_i;
  logic        rd_i;
  logic [31:0] rdat_o;
  logic [15:0] rd_len_o;
  logic [31:0] rd_seq_num_o;
  logic        rd_rdy_o;
  logic        rd_op_stop_i;
  logic [31:0] ack_num_o;
  logic        ack_req_o;
  logic        fin_rcv_o;
  logic        drop_o;

  modport master (
    output controller_work_st_i, init_seq_ld_i, init_seq_i,
           seg_sop_i, seg_seq_num_i, seg_len_i, seg_fin_flag_i, seg_rst_flag_i,
           seg_wr_i, seg_dat_i, seg_eop_i, seg_err_i, rd_i, rd_op_stop_i,
    input  rdat_o, rd_len_o, rd_seq_num_o, rd_rdy_o,
           ack_num_o, ack_req_o, fin_rcv_o, drop_o
  );

  modport slave (
    input  controller_work_st_i, init_seq_ld_i, init_seq_i,
           seg_sop_i, seg_seq_num_i, seg_len_i, seg_fin_flag_i, seg_rst_flag_i,
           seg_wr_i, seg_dat_i, seg_eop_i, seg_err_i, rd_i, rd_op_stop_i,
    output rdat_o, rd_len_o, rd_seq_num_o, rd_rdy_o,
           ack_num_o, ack_req_o, fin_rcv_o, drop_o
  );

endinterface

// File: rtl/tcp_rcv_ram.sv
// Purpose: simple dual-port RAM, one write port, one registered read port.
// Ports: clk; we_i/waddr_i/wdat_i write; re_i/raddr_i read, rdat_o valid one cycle after re_i.
// No reset on storage or read register; contents are undefined until written.
module tcp_rcv_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdat_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdat_i;
    if (re_i) rdat_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/tcp_rcv_memory.sv
// Purpose: buffers one in-order TCP segment payload, tracks rcv_nxt, requests ACKs.
// Ports: clk, rst (sync, active high) plus tcp_rcv_memory_if.slave bus.
// Pulses (ack_req/fin_rcv/drop) and ack_num are registered and change together.
module tcp_rcv_memory
  import tcp_rcv_pkg::*;
#(
  parameter int unsigned ADDR_W  = RCV_ADDR_W,
  parameter int unsigned MAX_LEN = RCV_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  tcp_rcv_memory_if.slave   bus
);

  state_e            state_q, state_d;
  logic [31:0]       rcv_nxt_q, rcv_nxt_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;    // one extra bit so a full 512-word payload fits
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       rd_len_q, rd_len_d;
  logic [31:0]       rd_seq_q, rd_seq_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic [31:0]       seg_seq_q, seg_seq_d;
  logic [15:0]       seg_len_q, seg_len_d;
  logic              seg_fin_q, seg_fin_d;
  logic              seg_err_q, seg_err_d;
  logic              disc_rst_q, disc_rst_d;
  logic              ack_req_q, ack_req_d;
  logic              fin_rcv_q, fin_rcv_d;
  logic              drop_q, drop_d;

  logic              ram_we;
  logic              ram_re;
  logic              in_window;

  // A segment is taken only if it starts exactly at rcv_nxt, fits the buffer and is not a RST.
  assign in_window = (bus.seg_seq_num_i == rcv_nxt_q) &&
                     (32'(bus.seg_len_i) <= MAX_LEN) &&
                     !bus.seg_rst_flag_i;

  always_comb begin
    state_d    = state_q;
    rcv_nxt_d  = rcv_nxt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_seq_d   = rd_seq_q;
    rd_rdy_d   = rd_rdy_q;
    seg_seq_d  = seg_seq_q;
    seg_len_d  = seg_len_q;
    seg_fin_d  = seg_fin_q;
    seg_err_d  = seg_err_q;
    disc_rst_d = disc_rst_q;
    ack_req_d  = 1'b0;
    fin_rcv_d  = 1'b0;
    drop_d     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = rd_rdy_q && bus.rd_i;

    // Reader side runs independently of the segment FSM while the buffer is held,
    // so data stays readable while a duplicate segment is being discarded.
    if (ram_re) rd_addr_d = rd_addr_q + ADDR_W'(1);
    if (rd_rdy_q && bus.rd_op_stop_i) begin
      rd_rdy_d  = 1'b0;
      rd_addr_d = '0;
    end

    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (bus.seg_sop_i) begin
          seg_seq_d  = bus.seg_seq_num_i;
          seg_len_d  = bus.seg_len_i;
          seg_fin_d  = bus.seg_fin_flag_i;
          seg_err_d  = 1'b0;
          disc_rst_d = bus.seg_rst_flag_i;
          wr_cnt_d   = '0;
          // An occupied buffer cannot take another segment, even an in-order one.
          state_d    = (state_q == ST_IDLE && in_window) ? ST_WRITE : ST_DISCARD;
        end else if (state_q == ST_FULL && !rd_rdy_d) begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Words past the declared length are padding from the parser; drop them.
        if (bus.seg_wr_i && (16'(wr_cnt_q) < word_count(seg_len_q))) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
        end
        if (bus.seg_eop_i) begin
          seg_err_d = bus.seg_err_i;
          state_d   = ST_CHECK;
        end
      end

      ST_DISCARD: begin
        if (bus.seg_eop_i) begin
          drop_d    = 1'b1;
          ack_req_d = !disc_rst_q;  // duplicate ACK restates the unchanged rcv_nxt
          if (disc_rst_q) begin
            // Peer reset the connection: whatever we were holding is stale.
            rd_rdy_d  = 1'b0;
            rd_addr_d = '0;
          end
          state_d = rd_rdy_d ? ST_FULL : ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (seg_err_q) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // FIN consumes one sequence number; 32-bit add wraps naturally.
          rcv_nxt_d = rcv_nxt_q + 32'(seg_len_q) + 32'(seg_fin_q);
          ack_req_d = 1'b1;
          fin_rcv_d = seg_fin_q;
          if (seg_len_q != 16'd0) begin
            rd_rdy_d  = 1'b1;
            rd_addr_d = '0;
            rd_len_d  = seg_len_q;
            rd_seq_d  = seg_seq_q;
            state_d   = ST_FULL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Leaving the work state abandons everything except the sequence space.
    if (!bus.controller_work_st_i) begin
      state_d   = ST_IDLE;
      rd_rdy_d  = 1'b0;
      rd_addr_d = '0;
      wr_cnt_d  = '0;
      rcv_nxt_d = rcv_nxt_q;
      ack_req_d = 1'b0;
      fin_rcv_d = 1'b0;
      drop_d    = 1'b0;
      ram_we    = 1'b0;
    end

    // Handshake load wins over any same-cycle advance from CHECK.
    if (bus.init_seq_ld_i) rcv_nxt_d = bus.init_seq_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rcv_nxt_q  <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_seq_q   <= '0;
      rd_rdy_q   <= 1'b0;
      seg_seq_q  <= '0;
      seg_len_q  <= '0;
      seg_fin_q  <= 1'b0;
      seg_err_q  <= 1'b0;
      disc_rst_q <= 1'b0;
      ack_req_q  <= 1'b0;
      fin_rcv_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcv_nxt_q  <= rcv_nxt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_seq_q   <= rd_seq_d;
      rd_rdy_q   <= rd_rdy_d;
      seg_seq_q  <= seg_seq_d;
      seg_len_q  <= seg_len_d;
      seg_fin_q  <= seg_fin_d;
      seg_err_q  <= seg_err_d;
      disc_rst_q <= disc_rst_d;
      ack_req_q  <= ack_req_d;
      fin_rcv_q  <= fin_rcv_d;
      drop_q     <= drop_d;
    end
  end

  tcp_rcv_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we && !rst),
    .waddr_i (wr_cnt_q[ADDR_W-1:0]),
    .wdat_i  (bus.seg_dat_i),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdat_o  (bus.rdat_o)
  );

  assign bus.ack_num_o    = rcv_nxt_q;
  assign bus.ack_req_o    = ack_req_q;
  assign bus.fin_rcv_o    = fin_rcv_q;
  assign bus.drop_o       = drop_q;
  assign bus.rd_rdy_o     = rd_rdy_q;
  assign bus.rd_len_o     = rd_len_q;
  assign bus.rd_seq_num_o = rd_seq_q;

endmodule

// File: tb/tb_tcp_rcv_memory.sv
// Purpose: self-checking bench for tcp_rcv_memory: segment table plus corner-case sequences.
// Events (ack/fin/drop + ack_num) and read data are checked against scoreboard queues.
// Inputs change 1 ns after the rising edge; outputs are sampled away from the edge.
module tb_tcp_rcv_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_rcv_memory_if bus();

  tcp_rcv_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ev_cnt   = 0;

  logic [34:0] exp_ev_q[$];   // {ack_req, fin_rcv, drop, ack_num}
  logic [31:0] exp_dat_q[$];  // words the reader should see from the held buffer

  typedef struct {
    logic        do_ld;
    logic [31:0] ld_val;
    logic [31:0] seq;
    logic [15:0] len;
    logic        fin;
    logic        rstf;
    logic        err;
    int          nw;
    logic        rd_after;
    logic        e_ack;
    logic        e_fin;
    logic        e_drop;
    logic [31:0] e_num;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [34:0] mk_ev(input logic a, input logic f, input logic d,
                                        input logic [31:0] n);
    return {a, f, d, n};
  endfunction

  // Every cycle with any pulse is one event; it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.ack_req_o || bus.fin_rcv_o || bus.drop_o)) begin
      ev_cnt++;
      if (exp_ev_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got ack=%0b fin=%0b drop=%0b num=0x%0h, expected none",
                 bus.ack_req_o, bus.fin_rcv_o, bus.drop_o, bus.ack_num_o);
      end else begin
        check("event", 64'({bus.ack_req_o, bus.fin_rcv_o, bus.drop_o, bus.ack_num_o}),
              64'(exp_ev_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input logic [31:0] v);
    bus.init_seq_ld_i = 1'b1;
    bus.init_seq_i    = v;
    step();
    bus.init_seq_ld_i = 1'b0;
  endtask

  task automatic send_seg(input logic [31:0] seq, input logic [15:0] len, input logic fin,
                          input logic rstf, input logic err, input int nw,
                          input logic [31:0] base);
    bus.seg_sop_i      = 1'b1;
    bus.seg_seq_num_i  = seq;
    bus.seg_len_i      = len;
    bus.seg_fin_flag_i = fin;
    bus.seg_rst_flag_i = rstf;
    step();
    bus.seg_sop_i = 1'b0;
    for (int i = 0; i < nw; i++) begin
      bus.seg_wr_i  = 1'b1;
      bus.seg_dat_i = base + 32'(i);
      step();
    end
    bus.seg_wr_i  = 1'b0;
    bus.seg_eop_i = 1'b1;
    bus.seg_err_i = err;
    step();
    bus.seg_eop_i = 1'b0;
    bus.seg_err_i = 1'b0;
  endtask

  task automatic wait_event(input string name);
    int start;
    bit seen;
    start = ev_cnt;
    seen  = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step();
      if (ev_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: got no event in 12 cycles, expected one", name);
      exp_ev_q.delete();
    end
    repeat (3) step();  // strays show up as unexpected pulses
  endtask

  task automatic read_all_and_stop(input string name);
    while (exp_dat_q.size() > 0) begin
      bus.rd_i = 1'b1;
      step();
      check({name, "_rdat"}, 64'(bus.rdat_o), 64'(exp_dat_q.pop_front()));
    end
    bus.rd_i         = 1'b0;
    bus.rd_op_stop_i = 1'b1;
    step();
    bus.rd_op_stop_i = 1'b0;
    step();
    check({name, "_rdy_after_stop"}, 64'(bus.rd_rdy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int nkeep;
    //          ld    ld_val         seq            len     fin   rstf  err   nw rd    ack   fin   drop  num            rdy
    vecs[0]  = '{1'b1, 32'h0000_1000, 32'h0000_1000, 16'd10, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_100A, 1'b1};
    vecs[1]  = '{1'b1, 32'h0000_1000, 32'h0000_1005, 16'd4,  1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 16'd4,  1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,         32'h0000_0002, 16'd8,  1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,         32'h0000_0002, 16'd8,  1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0000_0002, 16'd2049, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_2000, 32'h0000_2000, 16'd0,  1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2001, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         32'h0000_2001, 16'd5,  1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2006, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         32'h0000_2006, 16'd4,  1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2006, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,         32'h0000_2006, 16'd4,  1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_200A, 1'b1};
    vecs[10] = '{1'b0, 32'h0,         32'h0000_200A, 16'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_200A, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         32'h0000_200A, 16'd8,  1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2012, 1'b1};

    bus.controller_work_st_i = 1'b1;
    bus.init_seq_ld_i  = 1'b0;  bus.init_seq_i     = '0;
    bus.seg_sop_i      = 1'b0;  bus.seg_seq_num_i  = '0;
    bus.seg_len_i      = '0;    bus.seg_fin_flag_i = 1'b0;
    bus.seg_rst_flag_i = 1'b0;  bus.seg_wr_i       = 1'b0;
    bus.seg_dat_i      = '0;    bus.seg_eop_i      = 1'b0;
    bus.seg_err_i      = 1'b0;  bus.rd_i           = 1'b0;
    bus.rd_op_stop_i   = 1'b0;

    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_ack_num", 64'(bus.ack_num_o), 64'd0);
    check("reset_rd_rdy",  64'(bus.rd_rdy_o),  64'd0);
    check("reset_rd_len",  64'(bus.rd_len_o),  64'd0);
    check("reset_rd_seq",  64'(bus.rd_seq_num_o), 64'd0);
    check("reset_pulses",  64'({bus.ack_req_o, bus.fin_rcv_o, bus.drop_o}), 64'd0);

    for (int k = 0; k < 12; k++) begin
      logic [31:0] base;
      v    = vecs[k];
      base = 32'hA000_0000 + (32'(k) << 8);
      if (v.do_ld) load_seq(v.ld_val);
      exp_ev_q.push_back(mk_ev(v.e_ack, v.e_fin, v.e_drop, v.e_num));
      if (v.e_ack && !v.e_drop && v.len != 16'd0) begin
        nkeep = (int'(v.len) + 3) / 4;
        if (v.nw < nkeep) nkeep = v.nw;
        exp_dat_q.delete();
        for (int i = 0; i < nkeep; i++) exp_dat_q.push_back(base + 32'(i));
      end
      send_seg(v.seq, v.len, v.fin, v.rstf, v.err, v.nw, base);
      wait_event($sformatf("vec%0d", k));
      if (!v.e_rdy) exp_dat_q.delete();
      check($sformatf("vec%0d_ack_num", k), 64'(bus.ack_num_o), 64'(v.e_num));
      check($sformatf("vec%0d_rd_rdy", k),  64'(bus.rd_rdy_o),  64'(v.e_rdy));
      if (v.e_ack && !v.e_drop && v.len != 16'd0) begin
        check($sformatf("vec%0d_rd_len", k), 64'(bus.rd_len_o),     64'(v.len));
        check($sformatf("vec%0d_rd_seq", k), 64'(bus.rd_seq_num_o), 64'(v.seq));
      end
      if (v.rd_after) read_all_and_stop($sformatf("vec%0d", k));
    end

    // Controller leaves work state mid-WRITE: flush, no pulses, rcv_nxt kept.
    load_seq(32'h0000_3000);
    bus.seg_sop_i = 1'b1; bus.seg_seq_num_i = 32'h0000_3000; bus.seg_len_i = 16'd8;
    bus.seg_fin_flag_i = 1'b0; bus.seg_rst_flag_i = 1'b0;
    step();
    bus.seg_sop_i = 1'b0;
    bus.seg_wr_i = 1'b1; bus.seg_dat_i = 32'hDEAD_0000;
    step();
    bus.seg_wr_i = 1'b0;
    bus.controller_work_st_i = 1'b0;
    step();
    bus.controller_work_st_i = 1'b1;
    bus.seg_wr_i = 1'b1; bus.seg_dat_i = 32'hDEAD_0001;
    step();
    bus.seg_wr_i = 1'b0; bus.seg_eop_i = 1'b1;
    step();
    bus.seg_eop_i = 1'b0;
    repeat (6) step();
    check("flush_rd_rdy",  64'(bus.rd_rdy_o),  64'd0);
    check("flush_ack_num", 64'(bus.ack_num_o), 64'h3000);

    // Block must still accept the retransmission afterwards.
    exp_ev_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 32'h0000_3004));
    exp_dat_q.push_back(32'hBEEF_0001);
    send_seg(32'h0000_3000, 16'd4, 1'b0, 1'b0, 1'b0, 1, 32'hBEEF_0001);
    wait_event("after_flush");
    check("after_flush_rd_rdy", 64'(bus.rd_rdy_o), 64'd1);
    read_all_and_stop("after_flush");

    // Handshake load in the CHECK cycle overrides the advance; ACK still fires.
    exp_ev_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 32'h0000_5000));
    exp_dat_q.push_back(32'hC0DE_0001);
    send_seg(32'h0000_3004, 16'd4, 1'b0, 1'b0, 1'b0, 1, 32'hC0DE_0001);
    load_seq(32'h0000_5000);
    wait_event("ld_override");
    check("ld_override_ack_num", 64'(bus.ack_num_o), 64'h5000);
    check("ld_override_rd_len",  64'(bus.rd_len_o),  64'd4);
    read_all_and_stop("ld_override");

    // Reset in the middle of a segment returns everything to reset values.
    bus.seg_sop_i = 1'b1; bus.seg_seq_num_i = 32'h0000_5000; bus.seg_len_i = 16'd8;
    step();
    bus.seg_sop_i = 1'b0;
    bus.seg_wr_i = 1'b1; bus.seg_dat_i = 32'h1234_5678;
    step();
    bus.seg_wr_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("midrst_ack_num", 64'(bus.ack_num_o),    64'd0);
    check("midrst_rd_rdy",  64'(bus.rd_rdy_o),     64'd0);
    check("midrst_rd_len",  64'(bus.rd_len_o),     64'd0);
    check("midrst_rd_seq",  64'(bus.rd_seq_num_o), 64'd0);
    bus.seg_eop_i = 1'b1;
    step();
    bus.seg_eop_i = 1'b0;
    repeat (6) step();

    check("events_all_seen", 64'(exp_ev_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
